// File: rtl/pipe_checker.sv
// pipe_checker: drives exhaustive or LFSR-random stimulus into a pipelined DUT and
// compares the DUT output with a reference model LATENCY cycles after each vector is issued.
// Optional feature macro: PIPE_CHECKER_STOP_EN (stop the run on the first mismatch).
// Ports:
//   clk, rst          clock and synchronous active-high reset
//   start             begin a run (honoured in IDLE or DONE)
//   stall             DUT not advancing; freezes generator, delay line and compare
//   comp_in           stimulus to the DUT and the reference model
//   verify, comp_out  reference model output and DUT output
//   busy, done, pass  run status; pass valid while done
//   err_count         saturating mismatch count
//   fail_vec          stimulus of the first mismatch
module pipe_checker #(
  parameter int unsigned INBITS  = 8,
  parameter int unsigned OUTBITS = 8,
  parameter int unsigned LATENCY = 1,
  parameter int unsigned MODE    = 0,
  parameter int unsigned NVEC    = 16384,
  parameter logic [31:0] SEED    = 32'h1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               stall,
  output logic [INBITS-1:0]  comp_in,
  input  logic [OUTBITS-1:0] verify,
  input  logic [OUTBITS-1:0] comp_out,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic [15:0]        err_count,
  output logic [INBITS-1:0]  fail_vec
);

  localparam int unsigned CW      = 33;
  localparam logic [31:0] TAPS    = 32'h80200003;
  localparam logic [31:0] SEED_NZ = (SEED == 32'h0) ? 32'h1 : SEED;
  // Index of the final vector of a run.
  localparam logic [CW-1:0] LAST_IDX = (MODE == 1) ? CW'(NVEC - 1)
                                                   : ((CW'(1) << INBITS) - CW'(1));

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_e;

  // Right-shifting Galois LFSR step.
  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return s[0] ? ((s >> 1) ^ TAPS) : (s >> 1);
  endfunction

  state_e              state_q;
  logic [INBITS-1:0]   comp_in_q;
  logic                vld_q;
  logic [CW-1:0]       idx_q;
  logic [31:0]         lfsr_q;
  logic [LATENCY-1:0]  dl_vld_q;
  logic [INBITS-1:0]   dl_vec_q [LATENCY];
  logic                busy_q, done_q, pass_q;
  logic [15:0]         err_q;
  logic [INBITS-1:0]   fail_q;

  logic                mismatch;
  logic [15:0]         err_d;
  logic [INBITS-1:0]   fail_d;
  logic [LATENCY-1:0]  dl_vld_d;
  logic                drain_empty;
  logic [31:0]         first_lfsr, next_lfsr;
  logic [CW-1:0]       next_idx;
  logic [INBITS-1:0]   first_vec, next_vec;
  logic                last_issue;

  // Compare, error accounting and generator next values.
  always_comb begin
    mismatch    = !stall && dl_vld_q[LATENCY-1] && (comp_out !== verify);
    err_d       = err_q;
    fail_d      = fail_q;
    if (mismatch) begin
      err_d = (err_q == 16'hFFFF) ? err_q : err_q + 16'd1;
      if (err_q == 16'd0) fail_d = dl_vec_q[LATENCY-1];
    end
    dl_vld_d    = '0;
    dl_vld_d[0] = vld_q;
    for (int i = 1; i < LATENCY; i++) dl_vld_d[i] = dl_vld_q[i-1];
    drain_empty = (dl_vld_d == '0);
    first_lfsr  = lfsr_step(SEED_NZ);
    next_lfsr   = lfsr_step(lfsr_q);
    next_idx    = idx_q + CW'(1);
    first_vec   = (MODE == 1) ? first_lfsr[INBITS-1:0] : '0;
    next_vec    = (MODE == 1) ? next_lfsr[INBITS-1:0] : next_idx[INBITS-1:0];
    last_issue  = (idx_q == LAST_IDX);
  end

  // FSM, generator, delay line and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      comp_in_q <= '0;
      vld_q     <= 1'b0;
      idx_q     <= '0;
      lfsr_q    <= SEED_NZ;
      dl_vld_q  <= '0;
      for (int i = 0; i < LATENCY; i++) dl_vec_q[i] <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
      err_q     <= '0;
      fail_q    <= '0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            state_q   <= S_RUN;
            idx_q     <= '0;
            lfsr_q    <= first_lfsr;
            comp_in_q <= first_vec;
            vld_q     <= 1'b1;
            busy_q    <= 1'b1;
            done_q    <= 1'b0;
            pass_q    <= 1'b0;
            err_q     <= '0;
            fail_q    <= '0;
          end
        end
        default: begin
          if (!stall) begin
            dl_vld_q    <= dl_vld_d;
            dl_vec_q[0] <= comp_in_q;
            for (int i = 1; i < LATENCY; i++) dl_vec_q[i] <= dl_vec_q[i-1];
            err_q  <= err_d;
            fail_q <= fail_d;
            if (state_q == S_RUN) begin
              if (last_issue) begin
                state_q   <= S_DRAIN;
                comp_in_q <= '0;
                vld_q     <= 1'b0;
              end else begin
                idx_q     <= next_idx;
                lfsr_q    <= next_lfsr;
                comp_in_q <= next_vec;
              end
            end else if (drain_empty) begin
              state_q <= S_DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              pass_q  <= (err_d == 16'd0);
            end
`ifdef PIPE_CHECKER_STOP_EN
            // Abort on the first mismatch; flush the delay line so a later start is clean.
            if (mismatch) begin
              state_q   <= S_DONE;
              busy_q    <= 1'b0;
              done_q    <= 1'b1;
              pass_q    <= 1'b0;
              err_q     <= 16'd1;
              comp_in_q <= '0;
              vld_q     <= 1'b0;
              dl_vld_q  <= '0;
              $display("ERROR: %h expected %h got %h", dl_vec_q[LATENCY-1], verify, comp_out);
            end
`endif
          end
        end
      endcase
    end
  end

  assign comp_in   = comp_in_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign err_count = err_q;
  assign fail_vec  = fail_q;

endmodule
